// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding, request record and size helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_RD  = 3'd1,
        S_RMW_RD = 3'd2,
        S_ST_WR  = 3'd3,
        S_RESP   = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [2:0]  offset;
        logic [63:0] wdata;
    } lsu_req_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] size_log2(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_log2 = 2'd0;
            F3_H, F3_HU: size_log2 = 2'd1;
            F3_W, F3_WU: size_log2 = 2'd2;
            default:     size_log2 = 2'd3;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        f3_illegal = is_store ? (f3 > F3_D) : (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend, and sub-word store merge into the old word.
// Little-endian lanes; offset is already naturally aligned by the caller.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [63:0] i_word,
    input  logic [63:0] i_wdata,
    input  logic [2:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_ldata,
    output logic [63:0] o_merged
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [63:0] w_size_mask;
    logic [63:0] w_lane_mask;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_word >> w_shamt;

    always_comb begin
        w_size_mask = '1;
        case (size_log2(i_funct3))
            2'd0:    w_size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    w_size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    w_size_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_size_mask = '1;
        endcase

        o_ldata = w_shifted;
        case (i_funct3)
            F3_B:    o_ldata = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    o_ldata = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_ldata = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_BU:   o_ldata = {56'd0, w_shifted[7:0]};
            F3_HU:   o_ldata = {48'd0, w_shifted[15:0]};
            F3_WU:   o_ldata = {32'd0, w_shifted[31:0]};
            default: o_ldata = w_shifted;
        endcase
    end

    // SD degenerates to a full-lane replace at offset 0
    assign w_lane_mask = w_size_mask << w_shamt;
    assign o_merged    = (i_word & ~w_lane_mask) | ((i_wdata << w_shamt) & w_lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store stage in front of a word-only data memory; sub-word stores use read-modify-write.
// LSU_MISALIGN_TRAP_EN: misaligned accesses error out; otherwise the offset is aligned down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_is_store,
    input  logic [2:0]            i_req_funct3,
    input  logic [DATA_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    lsu_state_e            r_state;
    lsu_state_e            w_next;
    lsu_req_t              r_req;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [63:0]           r_word;
    logic                  r_err;

    logic       w_accept;
    logic       w_bad;
    logic [2:0] w_off_raw;
    logic [2:0] w_align_mask;
    logic [2:0] w_off_aligned;
    logic [63:0] w_ldata;
    logic [63:0] w_merged;
    logic       w_unused_addr;

    assign w_accept      = i_req_valid && o_req_ready;
    assign w_off_raw     = i_req_addr[2:0];
    assign w_unused_addr = &{1'b0, i_req_addr[DATA_WIDTH-1:ADDR_WIDTH+3]};

    always_comb begin
        w_align_mask = 3'b000;
        case (size_log2(i_req_funct3))
            2'd0:    w_align_mask = 3'b111;
            2'd1:    w_align_mask = 3'b110;
            2'd2:    w_align_mask = 3'b100;
            default: w_align_mask = 3'b000;
        endcase
    end

    assign w_off_aligned = w_off_raw & w_align_mask;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |(w_off_raw & ~w_align_mask);
    assign w_bad      = f3_illegal(i_req_is_store, i_req_funct3) || w_misalign;
`else
    assign w_bad      = f3_illegal(i_req_is_store, i_req_funct3);
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_waddr <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req   <= '{is_store: i_req_is_store, funct3: i_req_funct3,
                             offset: w_off_aligned, wdata: i_req_wdata};
                r_waddr <= i_req_addr[ADDR_WIDTH+2:3];
                r_err   <= w_bad;
            end
            if (r_state == S_LD_RD || r_state == S_RMW_RD) begin
                r_word <= i_mem_rdata;
            end
        end
    end

    lsu_byte_lane u_lane (
        .i_word   (r_word),
        .i_wdata  (r_req.wdata),
        .i_offset (r_req.offset),
        .i_funct3 (r_req.funct3),
        .o_ldata  (w_ldata),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_wdata  = '0;
        o_resp_valid = 1'b0;
        o_resp_err   = 1'b0;
        o_resp_rdata = '0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_bad)                   w_next = S_RESP;
                    else if (!i_req_is_store)    w_next = S_LD_RD;
                    else if (i_req_funct3 == F3_D) w_next = S_ST_WR;
                    else                         w_next = S_RMW_RD;
                end
            end
            S_LD_RD: begin
                o_mem_read = 1'b1;
                w_next     = S_RESP;
            end
            S_RMW_RD: begin
                o_mem_read = 1'b1;
                w_next     = S_ST_WR;
            end
            S_ST_WR: begin
                o_mem_write = 1'b1;
                o_mem_wdata = (r_req.funct3 == F3_D) ? r_req.wdata : w_merged;
                w_next      = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_err   = r_err;
                if (!r_req.is_store && !r_err) o_resp_rdata = w_ldata;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_mem_addr = r_waddr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_memory and a response scoreboard.
module tb_load_store_unit;

    localparam logic [63:0] ORIG = 64'hCAFEBABE_DEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    logic [63:0] mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [63:0] poke_data = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        err;
        int          cyc;
        logic [8:0]  rd;
        logic [8:0]  wr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write)    mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_is_store (req_is_store),
        .i_req_funct3   (req_funct3),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .i_mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [63:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request and follow it to its response, recording strobe cycles.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err, input int exp_cyc,
                          input logic [8:0] exp_rd, input logic [8:0] exp_wr);
        exp_t       e;
        logic [8:0] rd;
        logic [8:0] wr;
        bit         got;
        e.tag = tag; e.rdata = exp_rdata; e.err = exp_err;
        e.cyc = exp_cyc; e.rd = exp_rd; e.wr = exp_wr;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd = '0; wr = '0; got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            rd[c] = mem_read;
            wr[c] = mem_write;
            if (resp_valid) begin
                exp_t x;
                got = 1'b1;
                x = sb.pop_front();
                chk({x.tag, "_cyc"},   64'(c),   64'(x.cyc));
                chk({x.tag, "_rdata"}, resp_rdata, x.rdata);
                chk({x.tag, "_err"},   {63'd0, resp_err}, {63'd0, x.err});
                chk({x.tag, "_rd"},    {55'd0, rd}, {55'd0, x.rd});
                chk({x.tag, "_wr"},    {55'd0, wr}, {55'd0, x.wr});
            end
        end
        if (!got) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        logic wr_seen;
        #2;
        chk("rst_ready", {63'd0, req_ready},  64'd1);
        chk("rst_rvld",  {63'd0, resp_valid}, 64'd0);
        chk("rst_rd",    {63'd0, mem_read},   64'd0);
        chk("rst_wr",    {63'd0, mem_write},  64'd0);
        chk("rst_addr",  {54'd0, mem_addr},   64'd0);
        chk("rst_wdata", mem_wdata,           64'd0);
        chk("rst_rdata", resp_rdata,          64'd0);
        chk("rst_err",   {63'd0, resp_err},   64'd0);
        poke(10'd5, ORIG);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("lb28",  1'b0, 3'b000, 64'h28, 0, 64'hFFFFFFFF_FFFFFFEF, 1'b0, 2, 9'b10, 9'b0);
        do_req("lbu2f", 1'b0, 3'b100, 64'h2F, 0, 64'h00000000_000000CA, 1'b0, 2, 9'b10, 9'b0);
        do_req("lw2c",  1'b0, 3'b010, 64'h2C, 0, 64'hFFFFFFFF_CAFEBABE, 1'b0, 2, 9'b10, 9'b0);
        do_req("lwu2c", 1'b0, 3'b110, 64'h2C, 0, 64'h00000000_CAFEBABE, 1'b0, 2, 9'b10, 9'b0);
        do_req("ld28",  1'b0, 3'b011, 64'h28, 0, ORIG,                  1'b0, 2, 9'b10, 9'b0);
        do_req("lh2a",  1'b0, 3'b001, 64'h2A, 0, 64'hFFFFFFFF_FFFFDEAD, 1'b0, 2, 9'b10, 9'b0);
        do_req("lhu2e", 1'b0, 3'b101, 64'h2E, 0, 64'h00000000_0000CAFE, 1'b0, 2, 9'b10, 9'b0);

        do_req("sh2a",  1'b1, 3'b001, 64'h2A, 64'h1234, 0, 1'b0, 3, 9'b10, 9'b100);
        chk("sh2a_mem", mem[5], 64'hCAFEBABE_1234BEEF);
        do_req("ld_sh", 1'b0, 3'b011, 64'h28, 0, 64'hCAFEBABE_1234BEEF, 1'b0, 2, 9'b10, 9'b0);

        do_req("sd1ff8", 1'b1, 3'b011, 64'h1FF8, '1, 0, 1'b0, 2, 9'b0, 9'b10);
        chk("sd_mem1023", mem[1023], 64'hFFFFFFFF_FFFFFFFF);
        chk("sd_mem5",    mem[5],    64'hCAFEBABE_1234BEEF);
        do_req("ld1ff8", 1'b0, 3'b011, 64'h1FF8, 0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 2, 9'b10, 9'b0);
        do_req("ldwrap", 1'b0, 3'b011, 64'h2028, 0, 64'hCAFEBABE_1234BEEF, 1'b0, 2, 9'b10, 9'b0);

        do_req("ill_ld7", 1'b0, 3'b111, 64'h28, 0, 0, 1'b1, 1, 9'b0, 9'b0);
        do_req("ill_st4", 1'b1, 3'b100, 64'h28, 64'h55, 0, 1'b1, 1, 9'b0, 9'b0);
        chk("ill_mem5", mem[5], 64'hCAFEBABE_1234BEEF);

        poke(10'd5, ORIG);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw2a", 1'b0, 3'b010, 64'h2A, 0, 0, 1'b1, 1, 9'b0, 9'b0);
`else
        do_req("lw2a", 1'b0, 3'b010, 64'h2A, 0, 64'hFFFFFFFF_DEADBEEF, 1'b0, 2, 9'b10, 9'b0);
`endif

        do_req("sw2c",  1'b1, 3'b010, 64'h2C, 64'hAAAA_BBBB_1122_3344, 0, 1'b0, 3, 9'b10, 9'b100);
        chk("sw2c_mem", mem[5], 64'h11223344_DEADBEEF);

        // Reset while the read half of an SB is in flight
        poke(10'd5, ORIG);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 64'h29; req_wdata = 64'hA5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rd_strobe", {63'd0, mem_read}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        chk("mid_rst_rd",    {63'd0, mem_read},  64'd0);
        chk("mid_rst_addr",  {54'd0, mem_addr},  64'd0);
        chk("mid_rst_wdata", mem_wdata,          64'd0);
        wr_seen = mem_write;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_seen = wr_seen | mem_write | resp_valid;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_seen = wr_seen | mem_write | resp_valid;
        end
        chk("mid_rst_nowrite", {63'd0, wr_seen},   64'd0);
        chk("mid_rst_idle",    {63'd0, req_ready}, 64'd1);
        chk("mid_rst_mem5",    mem[5],             ORIG);

        do_req("sb29", 1'b1, 3'b000, 64'h29, 64'hFFFF_FFA5, 0, 1'b0, 3, 9'b10, 9'b100);
        do_req("ld_sb", 1'b0, 3'b011, 64'h28, 0, 64'hCAFEBABE_DEADA5EF, 1'b0, 2, 9'b10, 9'b0);

        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the SEQ RISC-V core. It sits directly upstream of `data_memory` and converts RV64 load/store requests (byte address, funct3, store data) into 64-bit word accesses on the `data_memory` port. It extracts and sign- or zero-extends load data. Sub-doubleword stores are done as a read-modify-write sequence, because `data_memory` has only whole-word writes.

## Interface
- `DATA_WIDTH`, 64, data width; fixed at 64 for RV64.
- `ADDR_WIDTH`, 10, `data_memory` word-address width (1024 doublewords).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
- `req_addr`  in  64  byte address from the ALU.
- `req_wdata`  in  64  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected (illegal funct3 or misaligned); valid with `resp_valid`.
- `mem_addr`  out  ADDR_WIDTH  word address, `req_addr[ADDR_WIDTH+2:3]`.
- `mem_wdata`  out  64  merged write word.
- `mem_read`, `mem_write`  out  1  `data_memory` strobes.
- `mem_rdata`  in  64  `data_memory` read data; combinational from `mem_addr` while `mem_read` is high.

## Operation
- The request is latched on the accept edge: `req_valid && req_ready`.
- Address bits above `ADDR_WIDTH+2` are ignored, so word addresses wrap modulo 2^ADDR_WIDTH.
- Byte offset is `addr[2:0]`. Lanes are little-endian: byte k occupies bits `[8k+7:8k]`.
- FSM states: IDLE, LD_RD, RMW_RD, ST_WR, RESP. Exits from IDLE on accept:
  - illegal funct3 (load 3'b111, store > 3'b011) or misaligned (see Configuration) -> RESP with err;
  - load -> LD_RD;
  - SD -> ST_WR;
  - SB/SH/SW -> RMW_RD.
- LD_RD: `mem_read`=1; `mem_rdata` is registered into the word buffer; -> RESP.
- RMW_RD: `mem_read`=1; word captured; -> ST_WR.
- ST_WR: `mem_write`=1, driving `mem_wdata`:
  - for sub-word stores, the buffered word with the target lanes replaced by the low bytes of `req_wdata`;
  - for SD, `req_wdata`.
  - Next state RESP.
- RESP: `resp_valid`=1 for exactly one cycle.
  - For loads, `resp_rdata` = the selected lanes shifted to bit 0, sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD).
  - Next state IDLE.
- `req_valid` outside IDLE is ignored; there is no queueing.
- Reset at any point: state -> IDLE. All outputs return to 0 immediately except `req_ready`, which is 1; `mem_addr`/`mem_wdata` are 0. A store interrupted before its ST_WR edge leaves memory unchanged.

## Timing
- Accept edge = edge 0. `resp_valid` is high in:
  - cycle 2 for loads and SD;
  - cycle 3 for SB/SH/SW;
  - cycle 1 for error responses.
- `mem_read`/`mem_write` are decoded from the state register; they are never both high and never high in IDLE or RESP.
- The store commits on the rising edge ending ST_WR.
- `req_ready` returns high in the cycle after RESP, so back-to-back throughput is one request per 3 or 4 cycles.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - an access whose offset is not a multiple of its size (H: offset[0]; W: offset[1:0]; D: offset[2:0]) is rejected with `resp_err`=1;
  - no memory strobe is raised.
- Undefined:
  - the offset is forced down to natural alignment (the low bits are cleared) and the access proceeds normally;
  - `resp_err` is raised only for illegal funct3.

## Structure
- Package `lsu_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU), the FSM state encoding, and the size-from-funct3 function.
- Sub-module `lsu_byte_lane` (combinational) has two jobs:
  - load extract/extend from (word, offset, funct3);
  - store merge from (old word, new data, offset, funct3).
- The FSM and registers live in `load_store_unit`.

## Test plan
All scenarios preload word 5 = 0xCAFEBABEDEADBEEF, i.e. bytes 0x28–0x2F.
- LB at 0x28 -> `resp_rdata`=0xFFFFFFFFFFFFFFEF in cycle 2; LBU at 0x2F -> 0x00000000000000CA.
- LW at 0x2C -> 0xFFFFFFFFCAFEBABE; LWU at 0x2C -> 0x00000000CAFEBABE; LD at 0x28 -> 0xCAFEBABEDEADBEEF.
- SH 0x1234 at 0x2A:
  - `mem_read` in cycle 1, `mem_write` in cycle 2, `resp_valid` in cycle 3;
  - a following LD at 0x28 returns 0xCAFEBABE1234BEEF.
- SD 0xFFFFFFFFFFFFFFFF at byte 0x1FF8 (word 1023): no `mem_read`; `resp_valid` in cycle 2. Address 0x2028 maps to word 5 (wrap).
- LW at 0x2A:
  - with the macro: `resp_err`=1 in cycle 1, no strobes;
  - without it: returns 0xFFFFFFFFDEADBEEF (aligned to 0x28).
- SB 0xA5 at 0x29 with `reset` driven low during RMW_RD: `mem_write` is never asserted, the FSM is in IDLE, and word 5 is unchanged.
